g9_cycle_sequencer: RTL and testbench

Multi-cycle control sequencer for the G9 processor datapath. It steps each instruction through fetch, decode, execute, optional memory and writeback, and emits the enables that gate PC update, instruction-register load, register-file write and data-memory access. It absorbs the read latency of the block-RAM instruction and data memories. It also provides run, single-step and halt control plus a retired-instruction counter. It sits between the decoded control signals and the PC, register file and memory write ports.

---
 rtl/g9_cycle_sequencer.sv | 105 ++++++++++
 tb/tb_g9_cycle_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/g9_cycle_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through fetch/decode/execute/memory/writeback
// and decodes the datapath strobes from the registered state and latency counter.
module g9_cycle_sequencer #(
  parameter int IMemLatency = 1,
  parameter int DMemLatency = 1,
  parameter int size        = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            step,
  input  logic            halt_req,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            reg_write_req,
  output logic            ir_load,
  output logic            pc_write,
  output logic            reg_write_en,
  output logic            dmem_read_en,
  output logic            dmem_write_en,
  output logic            busy,
  output logic            retired,
  output logic [2:0]      state,
  output logic [size-1:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    HALTED    = 3'd6
  } state_t;

  localparam logic [2:0] ILAST = 3'(IMemLatency - 1);
  localparam logic [2:0] DLAST = 3'(DMemLatency - 1);

  state_t     cur;
  logic [2:0] lat;
  logic       single;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur         <= IDLE;
      lat         <= 3'd0;
      single      <= 1'b0;
      instr_count <= '0;
    end else begin
      case (cur)
        IDLE: begin
          lat <= 3'd0;
          if (run) cur <= FETCH;
          else if (step) begin
            single <= 1'b1;
            cur    <= FETCH;
          end
        end
        FETCH: begin
          if (lat == ILAST) begin
            lat <= 3'd0;
            cur <= DECODE;
          end else lat <= lat + 3'd1;
        end
        DECODE: cur <= EXECUTE;
        EXECUTE: begin
          lat <= 3'd0;
          cur <= (mem_read | mem_write) ? MEMORY : WRITEBACK;
        end
        MEMORY: begin
          if (lat == DLAST) begin
            lat <= 3'd0;
            cur <= WRITEBACK;
          end else lat <= lat + 3'd1;
        end
        WRITEBACK: begin
          instr_count <= instr_count + 1'b1;
          lat         <= 3'd0;
          // the step request is consumed by this instruction whichever way we leave
          single      <= 1'b0;
          if (halt_req)    cur <= HALTED;
          else if (single) cur <= IDLE;
          else if (run)    cur <= FETCH;
          else             cur <= IDLE;
        end
        HALTED: if (!run && !halt_req) cur <= IDLE;
        default: begin
          cur <= IDLE;
          lat <= 3'd0;
        end
      endcase
    end
  end

  assign state         = cur;
  assign busy          = (cur != IDLE) && (cur != HALTED);
  assign ir_load       = (cur == FETCH) && (lat == ILAST);
  assign pc_write      = (cur == WRITEBACK);
  assign retired       = (cur == WRITEBACK);
  assign reg_write_en  = (cur == WRITEBACK) && reg_write_req;
  assign dmem_read_en  = (cur == MEMORY) && mem_read;
  assign dmem_write_en = (cur == MEMORY) && (lat == 3'd0) && mem_write;

endmodule

// File: tb/tb_g9_cycle_sequencer.sv
// Directed-vector bench for g9_cycle_sequencer: main instance (IMem=1, DMem=3) plus a
// narrow-counter instance (IMem=3, size=2) for fetch latency and counter wrap.
module tb_g9_cycle_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, run, step, halt_req, mem_read, mem_write, reg_write_req;
  logic        ir_load, pc_write, reg_write_en, dmem_read_en, dmem_write_en, busy, retired;
  logic [2:0]  state;
  logic [31:0] instr_count;

  logic        reset2, run2;
  logic        ir_load2, pc_write2, reg_write_en2, dmem_read_en2, dmem_write_en2, busy2, retired2;
  logic [2:0]  state2;
  logic [1:0]  instr_count2;

  g9_cycle_sequencer #(.IMemLatency(1), .DMemLatency(3), .size(32)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write_req(reg_write_req),
    .ir_load(ir_load), .pc_write(pc_write), .reg_write_en(reg_write_en),
    .dmem_read_en(dmem_read_en), .dmem_write_en(dmem_write_en), .busy(busy),
    .retired(retired), .state(state), .instr_count(instr_count)
  );

  g9_cycle_sequencer #(.IMemLatency(3), .DMemLatency(1), .size(2)) dut_w (
    .clk(clk), .reset(reset2), .run(run2), .step(1'b0), .halt_req(1'b0),
    .mem_read(1'b0), .mem_write(1'b0), .reg_write_req(1'b1),
    .ir_load(ir_load2), .pc_write(pc_write2), .reg_write_en(reg_write_en2),
    .dmem_read_en(dmem_read_en2), .dmem_write_en(dmem_write_en2), .busy(busy2),
    .retired(retired2), .state(state2), .instr_count(instr_count2)
  );

  int n_vec = 0;
  int n_err = 0;
  int alu_seq[4] = '{1, 2, 3, 5};
  int mem_seq[7] = '{1, 2, 3, 4, 4, 4, 5};
  int stp_seq[8] = '{1, 2, 3, 5, 0, 0, 0, 0};
  int w_seq[6]   = '{1, 1, 1, 2, 3, 5};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one clock; outputs are sampled 2 time units after the rising edge
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [5:0] strobes();
    return {ir_load, pc_write, reg_write_en, dmem_read_en, dmem_write_en, retired};
  endfunction

  initial begin
    int nret;
    reset = 1'b0; run = 1'b0; step = 1'b0; halt_req = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; reg_write_req = 1'b0;
    reset2 = 1'b0; run2 = 1'b0;

    // reset then idle, with decoded inputs high so the gating is exercised
    cyc(); cyc();
    reset = 1'b1; mem_read = 1'b1; mem_write = 1'b1; reg_write_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_state", state, 0);
      chk("idle_busy_strobes", {busy, strobes()}, 0);
      chk("idle_count", instr_count, 0);
    end

    // ALU stream: 4 cycles per instruction
    mem_read = 1'b0; mem_write = 1'b0; reg_write_req = 1'b1; run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("alu_state", state, alu_seq[i % 4]);
      chk("alu_strobes", strobes(),
          {(i % 4 == 0), (i % 4 == 3), (i % 4 == 3), 1'b0, 1'b0, (i % 4 == 3)});
      if (i == 19) run = 1'b0;
    end
    cyc();
    chk("alu_end_state", state, 0);
    chk("alu_count", instr_count, 5);

    // store, DMem=3: run dropped mid-instruction, instruction still completes
    mem_write = 1'b1; reg_write_req = 1'b0; run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("st_state", state, mem_seq[i]);
      chk("st_strobes", strobes(), {(i == 0), (i == 6), 1'b0, 1'b0, (i == 3), (i == 6)});
      if (i == 2) run = 1'b0;
    end
    cyc();
    chk("st_end_state", state, 0);
    chk("st_count", instr_count, 6);

    // single step; a second step while busy is ignored
    mem_write = 1'b0; reg_write_req = 1'b1; step = 1'b1;
    nret = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      step = (i == 1);
      chk("step_state", state, stp_seq[i]);
      if (retired) nret++;
    end
    chk("step_retired", nret, 1);
    chk("step_count", instr_count, 7);

    // halt raised during MEMORY of a load
    mem_read = 1'b1; reg_write_req = 1'b1; run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("halt_state", state, mem_seq[i]);
      chk("halt_strobes", strobes(),
          {(i == 0), (i == 6), (i == 6), (i >= 3 && i <= 5), 1'b0, (i == 6)});
      if (i == 3) halt_req = 1'b1;
    end
    cyc();
    chk("halted_state", state, 6);
    chk("halted_busy_strobes", {busy, strobes()}, 0);
    cyc();
    chk("halted_hold", state, 6);
    run = 1'b0; halt_req = 1'b0;
    cyc();
    chk("unhalt_state", state, 0);
    chk("halt_count", instr_count, 8);

    // reset during MEMORY of a store
    mem_read = 1'b0; mem_write = 1'b1; reg_write_req = 1'b0; run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rst_state", state, mem_seq[i]);
    end
    chk("rst_pre_wr", dmem_write_en, 1);
    reset = 1'b0; run = 1'b0;
    cyc();
    chk("rst_state_after", state, 0);
    chk("rst_busy_strobes", {busy, strobes()}, 0);
    chk("rst_count", instr_count, 0);
    reset = 1'b1;
    cyc();
    chk("rst_release", state, 0);

    // IMem=3 fetch latency and 2-bit counter wrap
    reset2 = 1'b1; run2 = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cyc();
      chk("w_state", state2, w_seq[i % 6]);
      chk("w_irload", ir_load2, (i % 6 == 2));
      if (i == 18) chk("w_count3", instr_count2, 3);
      if (i == 23) run2 = 1'b0;
    end
    cyc();
    chk("w_end_state", state2, 0);
    chk("w_wrap", instr_count2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
